// File: rtl/regfile_dump_pkg.sv
// Purpose : shared types and constants for the register-file dumper.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, index width and default register width.
package regfile_dump_pkg;

   // Index width covers the full 32-entry architectural register file.
   localparam int IDX_W    = 5;
   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage : regfile_dump_pkg

// File: rtl/regfile_dumper.sv
// Purpose : walks registers 0..NUM_REGS-1 through one RF read port, streams {idx, value} beats.
// Latency : beat i valid after edge 2i+1 following the start edge; 1 beat per 2 cycles peak.
// Backpressure: beat held stable while dump_ready=0; each stalled cycle adds one cycle.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start                             begin a walk (honoured only in IDLE or DONE)
//   rf_port_req, rf_addr, rf_data     borrowed register-file read port (combinational read)
//   dump_valid, dump_ready            beat handshake
//   dump_idx, dump_data               beat payload
//   busy, done                        walk in progress / walk complete (held until next start)
//
// NUM_REGS must be a power of two no larger than 32.
module regfile_dumper
   import regfile_dump_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = XLEN_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             rf_port_req,
   output logic [IDX_W-1:0] rf_addr,
   input  logic [XLEN-1:0]  rf_data,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [IDX_W-1:0] dump_idx,
   output logic [XLEN-1:0]  dump_data,
   output logic             busy,
   output logic             done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   state_e           state_q,      state_d;
   logic [IDX_W-1:0] idx_q,        idx_d;
   logic             dump_valid_q, dump_valid_d;
   logic [IDX_W-1:0] dump_idx_q,   dump_idx_d;
   logic [XLEN-1:0]  dump_data_q,  dump_data_d;
   logic             done_q,       done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_idx_q   <= '0;
         dump_data_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dump_valid_q <= dump_valid_d;
         dump_idx_q   <= dump_idx_d;
         dump_data_q  <= dump_data_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dump_valid_d = dump_valid_q;
      dump_idx_d   = dump_idx_q;
      dump_data_d  = dump_data_q;
      done_d       = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = FETCH;
               idx_d   = '0;
               done_d  = 1'b0;
            end
         end
         FETCH: begin
            // rf_addr already shows idx this cycle, so rf_data is the value to capture.
            dump_data_d  = rf_data;
            dump_idx_d   = idx_q;
            dump_valid_d = 1'b1;
            state_d      = SEND;
         end
         SEND: begin
            if (dump_valid_q && dump_ready) begin
               dump_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == FETCH) || (state_q == SEND);
   assign rf_port_req = busy;
   assign rf_addr     = idx_q;
   assign dump_valid  = dump_valid_q;
   assign dump_idx    = dump_idx_q;
   assign dump_data   = dump_data_q;
   assign done        = done_q;

endmodule : regfile_dumper

// File: tb/tb_regfile_dumper.sv
// Purpose : directed bench for regfile_dumper (32-register and 8-register instances).
// Latency : n/a.
// Backpressure: bench drives dump_ready, including a 3-cycle stall.
module tb_regfile_dumper;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // 32-register instance
   logic        start, dump_ready;
   logic        rf_port_req, dump_valid, busy, done;
   logic [4:0]  rf_addr, dump_idx;
   logic [31:0] rf_data, dump_data;
   logic [31:0] regs    [0:31];
   logic [31:0] exp_mem [0:31];
   assign rf_data = regs[rf_addr];

   // 8-register instance
   logic        start8, ready8;
   logic        req8, valid8, busy8, done8;
   logic [4:0]  addr8, idx8;
   logic [31:0] rdata8, ddata8;
   logic [31:0] regs8 [0:31];
   assign rdata8 = regs8[addr8];

   regfile_dumper #(.NUM_REGS(32), .XLEN(32)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .start(start),
      .rf_port_req(rf_port_req), .rf_addr(rf_addr), .rf_data(rf_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data),
      .busy(busy), .done(done)
   );

   regfile_dumper #(.NUM_REGS(8), .XLEN(32)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8),
      .rf_port_req(req8), .rf_addr(addr8), .rf_data(rdata8),
      .dump_valid(valid8), .dump_ready(ready8),
      .dump_idx(idx8), .dump_data(ddata8),
      .busy(busy8), .done(done8)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int edge_n   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // One full walk on the 32-register instance. Edge 0 is the edge sampling start.
   task automatic dump32(input int stall_beat, input int stall_n, input int poke_beat,
                         input bit wr9, output int done_edge, output int nbeats);
      int  stalls_left;
      bit  written;
      stalls_left = stall_n;
      written     = 1'b0;
      done_edge   = -1;
      nbeats      = 0;
      dump_ready  = 1'b1;
      start       = 1'b1;
      edge_n      = -1;
      tick();
      start = 1'b0;
      check("start_accepted", {57'd0, done, busy, rf_addr}, 64'b0100000);
      for (int k = 0; k < 300; k++) begin
         start      = 1'b0;
         dump_ready = 1'b1;
         if (done) begin
            done_edge = edge_n;
            break;
         end
         if (dump_valid) begin
            if (int'(dump_idx) == poke_beat) start = 1'b1;
            if (int'(dump_idx) == stall_beat && stalls_left > 0) begin
               check("stall_idx",  {59'd0, dump_idx}, 64'(stall_beat));
               check("stall_data", {32'd0, dump_data}, {32'd0, exp_mem[stall_beat]});
               stalls_left--;
               dump_ready = 1'b0;
            end else begin
               check("beat_idx",  {59'd0, dump_idx}, 64'(nbeats));
               check("beat_data", {32'd0, dump_data}, {32'd0, exp_mem[nbeats[4:0]]});
               nbeats++;
            end
         end else if (wr9 && !written && busy && rf_addr == 5'd9) begin
            // register write commits on the falling edge inside the FETCH cycle
            @(negedge clk);
            regs[9] = 32'h1234;
            written = 1'b1;
         end
         tick();
      end
      if (done_edge < 0) check("dump32_timeout", 64'd0, 64'd1);
      check("idle_after_done", {61'd0, busy, rf_port_req, dump_valid}, 64'd0);
   endtask

   initial begin
      int de, nb;
      reset_n    = 1'b0;
      start      = 1'b0;
      dump_ready = 1'b1;
      start8     = 1'b0;
      ready8     = 1'b1;
      for (int i = 0; i < 32; i++) begin
         regs[i]    = 32'd0;
         exp_mem[i] = 32'd0;
         regs8[i]   = 32'h100 + i;
      end
      regs[2]    = 32'h2ffc;     exp_mem[2] = 32'h2ffc;
      regs[5]    = 32'hdeadbeef; exp_mem[5] = 32'hdeadbeef;

      // reset state, before any clock edge
      #3;
      check("rst_outs32", {rf_port_req, dump_valid, busy, done, rf_addr, dump_idx, dump_data}, 64'd0);
      check("rst_outs8",  {req8, valid8, busy8, done8, addr8, idx8, ddata8}, 64'd0);
      #10;
      reset_n = 1'b1;
      tick();
      tick();
      check("idle_no_start", {61'd0, busy, dump_valid, done}, 64'd0);

      // plain walk with ready held high
      dump32(-1, 0, -1, 1'b0, de, nb);
      check("plain_nbeats", 64'(nb), 64'd32);
      check("plain_done_edge", 64'(de), 64'd64);

      // restart from DONE, 3-cycle stall on beat 7, stray start during beat 10
      dump32(7, 3, 10, 1'b0, de, nb);
      check("stall_nbeats", 64'(nb), 64'd32);
      check("stall_done_edge", 64'(de), 64'd67);

      // falling-edge write to x9 during its FETCH cycle
      exp_mem[9] = 32'h1234;
      dump32(-1, 0, -1, 1'b1, de, nb);
      check("wr9_nbeats", 64'(nb), 64'd32);
      check("wr9_done_edge", 64'(de), 64'd64);

      // asynchronous reset in the middle of beat 12
      start = 1'b1;
      tick();
      start = 1'b0;
      dump_ready = 1'b1;
      begin
         bit found;
         found = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (dump_valid && dump_idx == 5'd12) begin
               found = 1'b1;
               break;
            end
            tick();
         end
         check("reach_beat12", {63'd0, found}, 64'd1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_outs", {rf_port_req, dump_valid, busy, done, rf_addr, dump_idx, dump_data}, 64'd0);
      #3;
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("post_rst_quiet", {60'd0, busy, rf_port_req, dump_valid, done}, 64'd0);
      end

      // 8-register instance
      begin
         int n8, de8;
         n8  = 0;
         de8 = -1;
         ready8 = 1'b1;
         start8 = 1'b1;
         edge_n = -1;
         tick();
         start8 = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (done8) begin
               de8 = edge_n;
               break;
            end
            if (valid8) begin
               check("b8_idx",  {59'd0, idx8}, 64'(n8));
               check("b8_data", {32'd0, ddata8}, 64'(32'h100 + n8));
               n8++;
            end
            tick();
         end
         check("b8_nbeats", 64'(n8), 64'd8);
         check("b8_done_edge", 64'(de8), 64'd16);
         check("b8_idle", {62'd0, busy8, req8}, 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_regfile_dumper

// File: doc/regfile_dumper.md
# regfile_dumper

Read-side companion to the CPU register file: after the core halts, it walks every architectural register through a register-file read port and streams `{index, value}` beats out over a valid/ready handshake. It feeds the testbench dump and the debug/UART path. It sits beside the decode stage and takes over one read port (via `rf_port_req`) only while dumping. Register writes commit on the falling edge, so the dumper, which samples on rising edges, sees every write retired before `start`.

## Interface

Parameters:
- `NUM_REGS`, default 32: number of registers walked. Must be a power of two and at most 32.
- `XLEN`, default 32: register width.

Ports:
- `clk` (in, 1): clock. All state updates on the rising edge.
- `reset_n` (in, 1): reset, asynchronous and active-low.
- `start` (in, 1): begin a dump. Sampled at a rising edge; ignored unless the FSM is in IDLE or DONE.
- `rf_port_req` (out, 1): the dumper owns the read port. The core mux selects `rf_addr` while this is high.
- `rf_addr` (out, 5): read address to the register file.
- `rf_data` (in, XLEN): asynchronous read data for `rf_addr`.
- `dump_valid` (out, 1): beat available.
- `dump_ready` (in, 1): sink accepts the beat.
- `dump_idx` (out, 5): register index of the current beat.
- `dump_data` (out, XLEN): register value of the current beat.
- `busy` (out, 1): dump in progress.
- `done` (out, 1): dump complete. Held until the next accepted `start` or reset.

## Operation

- States: `IDLE`, `FETCH`, `SEND`, `DONE`. Index counter `idx` is 5 bits wide.
- `IDLE` or `DONE` with `start`=1: go to `FETCH`, set `idx`=0, clear `done`.
- `FETCH`:
  - `rf_addr`=`idx`.
  - At the rising edge, register `dump_data`←`rf_data`, `dump_idx`←`idx`, set `dump_valid`=1, go to `SEND`.
- `SEND`:
  - Hold `dump_valid`, `dump_idx` and `dump_data` stable until `dump_valid && dump_ready` is sampled at a rising edge.
  - On that handshake, clear `dump_valid`.
  - If `idx`==`NUM_REGS-1`, go to `DONE` and set `done`=1.
  - Otherwise set `idx`←`idx+1` and go to `FETCH`.
- `rf_addr` always equals `idx`. The index does not wrap; the walk ends at `NUM_REGS-1`.
- `busy` = (state is `FETCH` or `SEND`). `rf_port_req` = `busy`.
- x0 is dumped like any other register; its value comes from the register file (expected 0).
- `start` while `busy` has no effect. `start` in `DONE` restarts the walk from index 0.
- The `dump_ready` level in `FETCH` is irrelevant.
- Reset values (asserted while `reset_n`=0, independent of `clk`):
  - state `IDLE`, `idx` 0.
  - `rf_addr` 0, `rf_port_req` 0.
  - `dump_valid` 0, `dump_idx` 0, `dump_data` 0.
  - `busy` 0, `done` 0.
- Reset mid-dump abandons the walk immediately. No partial beat is held; after release the FSM waits in `IDLE` for a new `start`.

## Timing

Edge 0 is the rising edge that samples `start`.
- Beat *i* is valid after edge 2i+1 when `dump_ready` is held at 1.
- Maximum throughput is 1 beat per 2 cycles.
- Each cycle of `dump_ready`=0 in `SEND` adds exactly one cycle.
- With `NUM_REGS`=32 and `dump_ready`=1 throughout, the last beat is accepted at edge 64. `done`=1 and `busy`=0 after edge 64.
- `rf_data` must settle within the cycle in which `rf_addr` is presented (combinational read).
- A register-file write on the falling edge inside a `FETCH` cycle is visible in that beat.

## Structure

- Package `regfile_dump_pkg` holds:
  - the state enum (`IDLE`, `FETCH`, `SEND`, `DONE`);
  - the localparams for the 5-bit index width and default `XLEN`.
- Single module. No sub-module: the FSM, counter and output registers are small enough to share one file.
- The read-port mux lives in the core top level, not in this block.

## Test plan

- Preload register file (x2=0x2ffc, x5=0xdeadbeef, others 0). Pulse `start`, hold `dump_ready`=1 → 32 beats, idx 0..31, beat 2=0x2ffc, beat 5=0xdeadbeef; `done` after edge 64.
- Backpressure: drop `dump_ready` for 3 cycles during beat 7 → `dump_idx`=7 and `dump_data` stable throughout, no beat lost or duplicated, `done` delayed by exactly 3 cycles.
- `start` pulsed again at beat 10 → ignored, sequence continues to 31. `start` in `DONE` → new walk from idx 0, `done` clears.
- Assert `reset_n`=0 asynchronously mid-beat 12 → all outputs 0 immediately, `rf_port_req`=0. After release, no beats until `start`.
- Write x9=0x1234 on the falling edge within the `FETCH` cycle of idx 9 → beat 9 carries 0x1234.
- `NUM_REGS`=8 → exactly 8 beats (idx 0..7), `done` after edge 16.
